// File: rtl/fifo_test_seq.sv
// FIFO exerciser: writes a burst of an incrementing pattern, reads it back,
// checks every returned word and counts mismatches and completed rounds.
module fifo_test_seq #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 16
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              full,
   input  logic              empty,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic              busy,
   output logic              done,
   output logic [7:0]        err_cnt,
   output logic [15:0]       round_cnt,
   output logic [2:0]        state_dbg
);

   // Strobe semantics: the FIFO takes one word on every cycle wr_en is high
   // and returns one word on rd_data the cycle after every cycle rd_en is
   // high; full/empty gate the strobes combinationally, so a strobe is
   // never raised into a full or empty FIFO.

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] BL = 8'(BURST_LEN);

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        wcnt;
   logic [7:0]        rcnt;
   logic [7:0]        nwr;
   logic [DATA_W-1:0] wpat;
   logic [DATA_W-1:0] epat;
   logic              rd_vld;
   logic              wr_last;
   logic              rd_last;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      done      = 1'b0;
      wr_last   = 1'b0;
      rd_last   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = WRITE;
         end
         WRITE: begin
            wr_en = !full && (wcnt < BL);
            // A full FIFO ends the burst early, but only once something is in it.
            wr_last = (wcnt == BL) || (full && (wcnt != 8'd0));
            if (wr_last) state_nxt = READ;
         end
         READ: begin
            rd_en   = !empty && (rcnt < nwr);
            rd_last = rd_en && (rcnt == nwr - 8'd1);
            if (rd_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign wr_data   = wpat;
   assign state_dbg = state;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt      <= 8'd0;
         rcnt      <= 8'd0;
         nwr       <= 8'd0;
         wpat      <= '0;
         epat      <= '0;
         rd_vld    <= 1'b0;
         err_cnt   <= 8'd0;
         round_cnt <= 16'd0;
      end else begin
         if ((state == IDLE) && start) begin
            wcnt <= 8'd0;
            rcnt <= 8'd0;
         end
         if (wr_en) begin
            wcnt <= wcnt + 8'd1;
            wpat <= wpat + 1'b1;
         end
         if (wr_last) begin
            nwr <= wcnt;
         end
         if (rd_en) begin
            rcnt <= rcnt + 8'd1;
         end
         // rd_en is low in IDLE, so the check flag is also clear on round entry.
         rd_vld <= rd_en;
         if (rd_vld) begin
            epat <= epat + 1'b1;
            if ((rd_data != epat) && (err_cnt != 8'hFF)) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end
         if (state == DONE) begin
            round_cnt <= round_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_test_seq.sv
// Directed bench for fifo_test_seq: an ideal FIFO model with adjustable depth,
// optional read-word corruption and a forced-empty override.
module tb_fifo_test_seq;

   localparam int DATA_W    = 8;
   localparam int BURST_LEN = 16;

   logic              sysclk = 1'b0;
   logic              rst_n  = 1'b0;
   logic              start  = 1'b0;
   logic              full;
   logic              empty;
   logic [DATA_W-1:0] rd_data = '0;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              busy;
   logic              done;
   logic [7:0]        err_cnt;
   logic [15:0]       round_cnt;
   logic [2:0]        state_dbg;

   int   fifo_depth  = 32;
   logic force_empty = 1'b0;
   int   corrupt_at  = -1;

   logic [DATA_W-1:0] mem [0:31];
   int   wp         = 0;
   int   rp         = 0;
   int   fcount     = 0;
   int   wr_total   = 0;
   int   rd_total   = 0;
   int   done_total = 0;
   logic overlap    = 1'b0;
   logic [DATA_W-1:0] wlog [$];

   int vectors     = 0;
   int miscompares = 0;

   fifo_test_seq #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .start     (start),
      .full      (full),
      .empty     (empty),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .round_cnt (round_cnt),
      .state_dbg (state_dbg)
   );

   always #5 sysclk = ~sysclk;

   assign full  = (fcount >= fifo_depth);
   assign empty = (fcount == 0) || force_empty;

   // Ideal FIFO plus event counters; the FIFO contents are flushed under reset.
   always @(posedge sysclk) begin
      if (!rst_n) begin
         wp      <= 0;
         rp      <= 0;
         fcount  <= 0;
         rd_data <= '0;
      end else if (wr_en) begin
         mem[wp] <= wr_data;
         wp      <= (wp + 1) % 32;
         fcount  <= fcount + 1;
      end else if (rd_en) begin
         rd_data <= (rd_total == corrupt_at) ? (mem[rp] ^ 8'h01) : mem[rp];
         rp      <= (rp + 1) % 32;
         fcount  <= fcount - 1;
      end
      if (wr_en) begin
         wr_total <= wr_total + 1;
         wlog.push_back(wr_data);
      end
      if (rd_en) rd_total <= rd_total + 1;
      if (done) done_total <= done_total + 1;
      if (wr_en && rd_en) overlap <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst_n = 1'b0;
      repeat (2) @(negedge sysclk);
      rst_n = 1'b1;
      @(negedge sysclk);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge sysclk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
   endtask

   initial begin
      int ws;
      int rs;
      int ds;
      int nd;
      bit ok;

      // Reset values
      @(negedge sysclk);
      check("rst_wr_en", wr_en, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_round_cnt", round_cnt, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge sysclk);
      check("idle_hold_busy", busy, 0);
      check("idle_hold_wr_en", wr_en, 0);

      // Ideal FIFO, full 16-word round
      ws = wr_total; rs = rd_total; ds = done_total;
      start = 1'b1;
      @(negedge sysclk);
      check("t1_first_wr_en", wr_en, 1);
      check("t1_first_wr_data", wr_data, 8'h00);
      start = 1'b0;
      wait_done(200, ok);
      check("t1_done_seen", ok, 1);
      check("t1_err_at_done", err_cnt, 0);
      @(negedge sysclk);
      check("t1_busy_after", busy, 0);
      check("t1_round_cnt", round_cnt, 1);
      check("t1_writes", wr_total - ws, 16);
      check("t1_reads", rd_total - rs, 16);
      check("t1_done_pulses", done_total - ds, 1);
      check("t1_wdata_first", wlog[ws], 8'h00);
      check("t1_wdata_last", wlog[ws + 15], 8'h0F);

      // Depth-8 FIFO: burst cut short by full
      do_reset();
      fifo_depth = 8;
      ws = wr_total; rs = rd_total;
      pulse_start();
      wait_done(200, ok);
      check("t2_done_seen", ok, 1);
      @(negedge sysclk);
      check("t2_writes", wr_total - ws, 8);
      check("t2_reads", rd_total - rs, 8);
      check("t2_wdata_last", wlog[ws + 7], 8'h07);
      check("t2_err_cnt", err_cnt, 0);
      check("t2_round_cnt", round_cnt, 1);
      ws = wr_total;
      pulse_start();
      wait_done(200, ok);
      check("t2b_done_seen", ok, 1);
      @(negedge sysclk);
      check("t2b_wdata_first", wlog[ws], 8'h08);
      check("t2b_err_cnt", err_cnt, 0);
      check("t2b_round_cnt", round_cnt, 2);
      fifo_depth = 32;

      // Third read word corrupted
      do_reset();
      corrupt_at = rd_total + 2;
      pulse_start();
      wait_done(200, ok);
      check("t3_done_seen", ok, 1);
      check("t3_err_cnt", err_cnt, 1);
      @(negedge sysclk);
      check("t3_round_cnt", round_cnt, 1);
      corrupt_at = -1;

      // start held for 20 back-to-back rounds, pattern wraps
      do_reset();
      ws = wr_total;
      nd = 0;
      start = 1'b1;
      @(negedge sysclk);
      for (int r = 0; r < 20; r++) begin
         wait_done(100, ok);
         if (!ok) break;
         nd++;
         if (nd == 20) start = 1'b0;
         @(negedge sysclk);
      end
      start = 1'b0;
      check("t4_rounds_seen", nd, 20);
      check("t4_round_cnt", round_cnt, 20);
      check("t4_err_cnt", err_cnt, 0);
      check("t4_writes", wr_total - ws, 320);
      check("t4_wrap_ff", wlog[ws + 255], 8'hFF);
      check("t4_wrap_00", wlog[ws + 256], 8'h00);
      check("t4_wdata_last", wlog[ws + 319], 8'h3F);
      @(negedge sysclk);
      check("t4_idle_after", busy, 0);

      // Reset in the middle of READ
      do_reset();
      rs = rd_total;
      pulse_start();
      for (int i = 0; i < 200 && (rd_total - rs) < 5; i++) @(negedge sysclk);
      check("t5_reached_read5", rd_total - rs, 5);
      check("t5_in_read", state_dbg, 3'd2);
      ds = done_total;
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_rd_en", rd_en, 0);
      check("t5_async_wr_en", wr_en, 0);
      check("t5_async_busy", busy, 0);
      check("t5_async_done", done, 0);
      check("t5_async_state", state_dbg, 3'd0);
      @(negedge sysclk);
      @(negedge sysclk);
      rst_n = 1'b1;
      repeat (50) @(negedge sysclk);
      check("t5_no_done", done_total - ds, 0);
      check("t5_still_idle", busy, 0);
      ws = wr_total;
      start = 1'b1;
      @(negedge sysclk);
      check("t5_fresh_wr_data", wr_data, 8'h00);
      start = 1'b0;
      wait_done(200, ok);
      check("t5_fresh_done", ok, 1);
      check("t5_fresh_err", err_cnt, 0);
      @(negedge sysclk);
      check("t5_fresh_round", round_cnt, 1);

      // empty forced high for 10 cycles mid-READ
      do_reset();
      rs = rd_total;
      pulse_start();
      for (int i = 0; i < 200 && (rd_total - rs) < 4; i++) @(negedge sysclk);
      check("t6_reached_read4", rd_total - rs, 4);
      force_empty = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1 check("t6_rd_en_blocked", rd_en, 0);
         @(negedge sysclk);
      end
      force_empty = 1'b0;
      check("t6_reads_frozen", rd_total - rs, 4);
      wait_done(200, ok);
      check("t6_done_seen", ok, 1);
      @(negedge sysclk);
      check("t6_reads", rd_total - rs, 16);
      check("t6_err_cnt", err_cnt, 0);
      check("t6_round_cnt", round_cnt, 1);

      check("no_wr_rd_overlap", overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
